// File: rtl/display_pkg.sv
// Shared constants for the hex seven-segment display path.
// Glyphs are active-high {a,b,c,d,e,f,g}, a = bit 6.
package display_pkg;

    localparam int unsigned SEG_W = 7;

    // All segments dark, active-high sense
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

    // Hex digit glyphs 0..F
    localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Nibble to active-high glyph
    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex7seg
    import display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] glyph_c
);

    // Table lookup from the shared glyph set
    assign glyph_c = hex_glyph(nibble);

endmodule

// File: rtl/display_mux_hex.sv
// Multiplexed multi-digit hex seven-segment driver with tear-free load
// handshake and a one-cycle anti-ghosting guard per digit slot.
// Optional build macro: HEX_DISPLAY_LZ_BLANK_EN enables leading-zero blanking.
module display_mux_hex
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned ACTIVE_LOW = 1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] valor,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [SEG_W-1:0]        seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    busy,
    output logic                    frame_tick
);

    localparam int unsigned DW  = 4 * NUM_DIGITS;
    localparam int unsigned PW  = $clog2(SCAN_DIV);
    localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic        POL = (ACTIVE_LOW != 0);

    localparam logic [SEG_W-1:0]      SEG_RST = POL ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_RST  = POL ? '1 : '0;

    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    logic [DW-1:0] shd;
    logic [DW-1:0] disp;
    logic          pend;

    logic                  pre_last_c;
    logic                  idx_last_c;
    logic                  wrap_c;
    logic [3:0]            nib_c;
    logic                  off_c;
    logic [SEG_W-1:0]      glyph_c;
    logic [SEG_W-1:0]      seg_hi_c;
    logic [NUM_DIGITS-1:0] an_hi_c;

    // Slot and frame boundary detection
    assign pre_last_c = (pre == PW'(SCAN_DIV - 1));
    assign idx_last_c = (idx == IW'(NUM_DIGITS - 1));
    assign wrap_c     = pre_last_c && idx_last_c;

`ifdef HEX_DISPLAY_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_c;
    logic                  zero_run;

    // Digit k>0 is blanked when it and all higher digits are zero
    always_comb begin
        lz_c     = '0;
        zero_run = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            zero_run = zero_run && (disp[4*k +: 4] == 4'h0);
            lz_c[k]  = zero_run;
        end
    end
`endif

    // Select the nibble and blanking for the digit currently scanned
    always_comb begin
        nib_c = 4'h0;
        off_c = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx == IW'(k)) begin
                nib_c = disp[4*k +: 4];
`ifdef HEX_DISPLAY_LZ_BLANK_EN
                off_c = blank_mask[k] | lz_c[k];
`else
                off_c = blank_mask[k];
`endif
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble  (nib_c),
        .glyph_c (glyph_c)
    );

    // Active-high output values before polarity; pre==0 is the guard cycle
    assign seg_hi_c = off_c ? SEG_OFF : glyph_c;
    assign an_hi_c  = (pre != '0) ? (NUM_DIGITS'(1) << idx) : '0;

    // Scan counters, load handshake and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pre        <= '0;
            idx        <= '0;
            shd        <= '0;
            disp       <= '0;
            pend       <= 1'b0;
            seg        <= SEG_RST;
            an         <= AN_RST;
            frame_tick <= 1'b0;
        end else begin
            if (pre_last_c) begin
                pre <= '0;
                idx <= idx_last_c ? '0 : idx + IW'(1);
            end else begin
                pre <= pre + PW'(1);
            end

            // Wrap moves the old shadow; a coincident load re-arms pend
            if (wrap_c && pend) begin
                disp <= shd;
                pend <= 1'b0;
            end
            if (load) begin
                shd  <= valor;
                pend <= 1'b1;
            end

            seg        <= POL ? ~seg_hi_c : seg_hi_c;
            an         <= POL ? ~an_hi_c : an_hi_c;
            frame_tick <= wrap_c;
        end
    end

    assign busy = pend;

endmodule

// File: tb/tb_display_mux_hex.sv
// Directed bench for display_mux_hex with NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
// cyc counts rising edges since the last reset edge E0; sampling is on negedge.
module tb_display_mux_hex;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] valor;
    logic [3:0]  blank_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    display_mux_hex #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .valor      (valor),
        .blank_mask (blank_mask),
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Drive a one-cycle load captured at the next edge
    task automatic pulse_load(input logic [15:0] v);
        valor = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; valor = '0; blank_mask = '0;
        @(negedge clk);
        tick();
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=%h", seg, 7'h7F); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=%h", an, 4'hF); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        rst = 1'b0;
        cyc = 0;
        run_to(1);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL e0p1_an got=%h exp=%h", an, 4'hF); end
        run_to(2);
        checks++; if (an !== 4'hE) begin errors++; $display("FAIL e0p2_an got=%h exp=%h", an, 4'hE); end
        checks++; if (seg !== 7'h01) begin errors++; $display("FAIL e0p2_seg got=%h exp=%h", seg, 7'h01); end
        run_to(5);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL guard1_an got=%h exp=%h", an, 4'hF); end
        run_to(6);
        checks++; if (an !== 4'hD) begin errors++; $display("FAIL slot1_an got=%h exp=%h", an, 4'hD); end
        run_to(13);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL guard3_an got=%h exp=%h", an, 4'hF); end
    endtask

    task automatic test_load();
        run_to(20);
        pulse_load(16'h1A2F);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_set got=%b exp=1", busy); end
        run_to(31);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_hold got=%b exp=1", busy); end
        run_to(32);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_clr got=%b exp=0", busy); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick32 got=%b exp=1", frame_tick); end
        run_to(33);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick33 got=%b exp=0", frame_tick); end
        run_to(34);
        checks++; if (seg !== 7'h38) begin errors++; $display("FAIL load_d0 got=%h exp=%h", seg, 7'h38); end
        run_to(38);
        checks++; if (seg !== 7'h12) begin errors++; $display("FAIL load_d1 got=%h exp=%h", seg, 7'h12); end
        run_to(42);
        checks++; if (seg !== 7'h08) begin errors++; $display("FAIL load_d2 got=%h exp=%h", seg, 7'h08); end
        checks++; if (an !== 4'hB) begin errors++; $display("FAIL load_an2 got=%h exp=%h", an, 4'hB); end
        run_to(46);
        checks++; if (seg !== 7'h4F) begin errors++; $display("FAIL load_d3 got=%h exp=%h", seg, 7'h4F); end
        run_to(48);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick48 got=%b exp=1", frame_tick); end
    endtask

    task automatic test_load_at_wrap();
        run_to(50);
        pulse_load(16'h1111);
        run_to(63);
        pulse_load(16'h2222);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrapld_busy got=%b exp=1", busy); end
        run_to(66);
        checks++; if (seg !== 7'h4F) begin errors++; $display("FAIL wrapld_old_d0 got=%h exp=%h", seg, 7'h4F); end
        run_to(78);
        checks++; if (seg !== 7'h4F) begin errors++; $display("FAIL wrapld_old_d3 got=%h exp=%h", seg, 7'h4F); end
        run_to(79);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrapld_busy79 got=%b exp=1", busy); end
        run_to(80);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrapld_busy80 got=%b exp=0", busy); end
        run_to(82);
        checks++; if (seg !== 7'h12) begin errors++; $display("FAIL wrapld_new_d0 got=%h exp=%h", seg, 7'h12); end
    endtask

    task automatic test_blank();
        run_to(86);
        checks++; if (seg !== 7'h12) begin errors++; $display("FAIL blank_d1 got=%h exp=%h", seg, 7'h12); end
        run_to(88);
        blank_mask = 4'b0100;
        run_to(89);
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL blank_d2_first got=%h exp=%h", seg, 7'h7F); end
        run_to(90);
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL blank_d2 got=%h exp=%h", seg, 7'h7F); end
        checks++; if (an !== 4'hB) begin errors++; $display("FAIL blank_an2 got=%h exp=%h", an, 4'hB); end
        run_to(92);
        blank_mask = 4'b0000;
        run_to(94);
        checks++; if (seg !== 7'h12) begin errors++; $display("FAIL blank_d3 got=%h exp=%h", seg, 7'h12); end
    endtask

    task automatic test_back_to_back();
        run_to(100);
        pulse_load(16'h3333);
        pulse_load(16'h4444);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        run_to(114);
        checks++; if (seg !== 7'h4C) begin errors++; $display("FAIL b2b_last_wins got=%h exp=%h", seg, 7'h4C); end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_hi;
`ifdef HEX_DISPLAY_LZ_BLANK_EN
        exp_hi = 7'h7F;
`else
        exp_hi = 7'h01;
`endif
        run_to(120);
        pulse_load(16'h00F0);
        run_to(130);
        checks++; if (seg !== 7'h01) begin errors++; $display("FAIL lz_d0 got=%h exp=%h", seg, 7'h01); end
        run_to(134);
        checks++; if (seg !== 7'h38) begin errors++; $display("FAIL lz_d1 got=%h exp=%h", seg, 7'h38); end
        run_to(138);
        checks++; if (seg !== exp_hi) begin errors++; $display("FAIL lz_d2 got=%h exp=%h", seg, exp_hi); end
        run_to(142);
        checks++; if (seg !== exp_hi) begin errors++; $display("FAIL lz_d3 got=%h exp=%h", seg, exp_hi); end
        run_to(145);
        pulse_load(16'h0000);
        run_to(162);
        checks++; if (seg !== 7'h01) begin errors++; $display("FAIL lz0_d0 got=%h exp=%h", seg, 7'h01); end
        run_to(166);
        checks++; if (seg !== exp_hi) begin errors++; $display("FAIL lz0_d1 got=%h exp=%h", seg, exp_hi); end
    endtask

    task automatic test_reset_mid();
        run_to(170);
        pulse_load(16'h5555);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
        rst = 1'b1;
        tick();
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rstmid_seg got=%h exp=%h", seg, 7'h7F); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL rstmid_an got=%h exp=%h", an, 4'hF); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy0 got=%b exp=0", busy); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick got=%b exp=0", frame_tick); end
        rst = 1'b0;
        cyc = 0;
        run_to(16);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL rstmid_tick16 got=%b exp=1", frame_tick); end
        run_to(18);
        checks++; if (seg !== 7'h01) begin errors++; $display("FAIL rstmid_d0 got=%h exp=%h", seg, 7'h01); end
        run_to(22);
        checks++; if (seg !== 7'h01) begin errors++; $display("FAIL rstmid_d1 got=%h exp=%h", seg, 7'h01); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_at_wrap();
        test_blank();
        test_back_to_back();
        test_leading_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
